// File: rtl/ddr3_init_sequencer.sv
// ddr3_init_sequencer
// DDR3 power-up / initialization sequencer. Drives the DRAM command pins
// through RESET# hold, CKE wait, tXPR, MR2/MR3/MR1/MR0 loads and ZQCL, one
// rank at a time, and then raises the sticky init_done and hands the bus back
// to the controller core.
//
// Optional build macro DDR3_INIT_SIM_SHORT_EN: when defined, the RESET# hold
// and CKE wait are each forced to 16 cycles so simulations skip the long
// power-up delays. All other timings come from the parameters.
//
// Handshake: none. The block free-runs from the release of rst. Each command
// ({ras,cas,we} != 111) is valid for exactly one clock cycle. The core must not
// drive the command bus until init_done is high.
//
// Timing convention: the down-counter is loaded with T on each state/command
// transition and the transition it guards happens on the edge where it reads
// 1. So an event scheduled T cycles after another appears on the registered
// outputs exactly T clock edges later.
module ddr3_init_sequencer #(
    parameter int NUM_CS       = 1,
    parameter int BA_BITS      = 3,
    parameter int ADDR_BITS    = 14,
    parameter int T_RESET_CYC  = 40000,
    parameter int T_CKE_CYC    = 100000,
    parameter int T_XPR_CYC    = 64,
    parameter int T_MRD_CYC    = 4,
    parameter int T_MOD_CYC    = 12,
    parameter int T_ZQINIT_CYC = 512,
    parameter logic [ADDR_BITS-1:0] MR0_VAL = '0,
    parameter logic [ADDR_BITS-1:0] MR1_VAL = '0,
    parameter logic [ADDR_BITS-1:0] MR2_VAL = '0,
    parameter logic [ADDR_BITS-1:0] MR3_VAL = '0
) (
    input  logic                                          ck,
    input  logic                                          rst,
    output logic                                          mem_rst_n,
    output logic                                          mem_cke,
    output logic [NUM_CS-1:0]                             mem_cs_n,
    output logic                                          mem_ras_n,
    output logic                                          mem_cas_n,
    output logic                                          mem_we_n,
    output logic [BA_BITS-1:0]                            mem_ba,
    output logic [ADDR_BITS-1:0]                          mem_addr,
    output logic                                          mem_odt,
    output logic                                          init_done,
    output logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cur_rank
);

    localparam int RANK_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

`ifdef DDR3_INIT_SIM_SHORT_EN
    localparam int EFF_RESET_CYC = 16;
    localparam int EFF_CKE_CYC   = 16;
`else
    localparam int EFF_RESET_CYC = T_RESET_CYC;
    localparam int EFF_CKE_CYC   = T_CKE_CYC;
`endif

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max_i(max_i(max_i(EFF_RESET_CYC, EFF_CKE_CYC),
                                       max_i(T_XPR_CYC, T_MRD_CYC)),
                                 max_i(T_MOD_CYC, T_ZQINIT_CYC));
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]     LD_RESET   = CNT_W'(EFF_RESET_CYC);
    localparam logic [CNT_W-1:0]     LD_CKE     = CNT_W'(EFF_CKE_CYC);
    localparam logic [CNT_W-1:0]     LD_XPR     = CNT_W'(T_XPR_CYC);
    localparam logic [CNT_W-1:0]     LD_MRD     = CNT_W'(T_MRD_CYC);
    localparam logic [CNT_W-1:0]     LD_MOD     = CNT_W'(T_MOD_CYC);
    localparam logic [CNT_W-1:0]     LD_ZQ      = CNT_W'(T_ZQINIT_CYC);
    localparam logic [RANK_W-1:0]    LAST_RANK  = RANK_W'(NUM_CS - 1);
    localparam logic [ADDR_BITS-1:0] ZQCL_ADDR  = ADDR_BITS'(1024);   // A10 = 1 (ZQ long)

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_MRS  = 3'b000;
    localparam logic [2:0] CMD_ZQCL = 3'b110;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_CKE_WAIT   = 3'd1,
        ST_XPR_WAIT   = 3'd2,
        ST_MRS        = 3'd3,
        ST_MOD_WAIT   = 3'd4,
        ST_ZQ_WAIT    = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            mr_idx_q, mr_idx_d;   // MRS commands already issued to this rank
    logic [RANK_W-1:0]     rank_q, rank_d;
    logic                  rst_n_q, rst_n_d;
    logic                  cke_q, cke_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [BA_BITS-1:0]    ba_q, ba_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  odt_q;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  sel_rank;

    assign tick = (cnt_q == CNT_ONE);

    // Next-state, counter reload and the one-cycle command for the next edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q > CNT_ONE) ? (cnt_q - CNT_ONE) : cnt_q;
        mr_idx_d = mr_idx_q;
        rank_d   = rank_q;
        cmd_d    = CMD_NOP;
        ba_d     = '0;
        addr_d   = '0;
        case (state_q)
            ST_RESET_HOLD: begin
                if (tick) begin
                    state_d = ST_CKE_WAIT;
                    cnt_d   = LD_CKE;
                end
            end
            ST_CKE_WAIT: begin
                if (tick) begin
                    state_d = ST_XPR_WAIT;
                    cnt_d   = LD_XPR;
                end
            end
            ST_XPR_WAIT: begin
                if (tick) begin
                    state_d  = ST_MRS;
                    cnt_d    = LD_MRD;
                    mr_idx_d = 2'd1;
                    cmd_d    = CMD_MRS;
                    ba_d     = BA_BITS'(2);
                    addr_d   = MR2_VAL;
                end
            end
            ST_MRS: begin
                if (tick) begin
                    cmd_d = CMD_MRS;
                    case (mr_idx_q)
                        2'd1: begin
                            ba_d   = BA_BITS'(3);
                            addr_d = MR3_VAL;
                        end
                        2'd2: begin
                            ba_d   = BA_BITS'(1);
                            addr_d = MR1_VAL;
                        end
                        default: begin
                            ba_d   = BA_BITS'(0);
                            addr_d = MR0_VAL;
                        end
                    endcase
                    if (mr_idx_q == 2'd3) begin
                        state_d = ST_MOD_WAIT;
                        cnt_d   = LD_MOD;
                    end else begin
                        mr_idx_d = mr_idx_q + 2'd1;
                        cnt_d    = LD_MRD;
                    end
                end
            end
            ST_MOD_WAIT: begin
                if (tick) begin
                    state_d = ST_ZQ_WAIT;
                    cnt_d   = LD_ZQ;
                    cmd_d   = CMD_ZQCL;
                    addr_d  = ZQCL_ADDR;
                end
            end
            ST_ZQ_WAIT: begin
                if (tick) begin
                    if (rank_q != LAST_RANK) begin
                        // Next rank starts its MR2 on the very cycle ZQinit expires.
                        rank_d   = rank_q + RANK_W'(1);
                        state_d  = ST_MRS;
                        cnt_d    = LD_MRD;
                        mr_idx_d = 2'd1;
                        cmd_d    = CMD_MRS;
                        ba_d     = BA_BITS'(2);
                        addr_d   = MR2_VAL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RESET_HOLD;
                cnt_d   = LD_RESET;
            end
        endcase
    end

    // Pin levels that follow from the state being entered on the next edge.
    always_comb begin
        rst_n_d  = (state_d != ST_RESET_HOLD);
        cke_d    = (state_d != ST_RESET_HOLD) && (state_d != ST_CKE_WAIT);
        done_d   = (state_d == ST_DONE);
        sel_rank = (state_d == ST_MRS) || (state_d == ST_MOD_WAIT) || (state_d == ST_ZQ_WAIT);
        cs_n_d   = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = !(sel_rank && (rank_d == RANK_W'(i)));
        end
    end

    // State, counter and registered output pins.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= ST_RESET_HOLD;
            cnt_q    <= LD_RESET;
            mr_idx_q <= 2'd0;
            rank_q   <= '0;
            rst_n_q  <= 1'b0;
            cke_q    <= 1'b0;
            cs_n_q   <= '1;
            cmd_q    <= CMD_NOP;
            ba_q     <= '0;
            addr_q   <= '0;
            odt_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mr_idx_q <= mr_idx_d;
            rank_q   <= rank_d;
            rst_n_q  <= rst_n_d;
            cke_q    <= cke_d;
            cs_n_q   <= cs_n_d;
            cmd_q    <= cmd_d;
            ba_q     <= ba_d;
            addr_q   <= addr_d;
            odt_q    <= 1'b0;     // termination stays off for the whole init
            done_q   <= done_d;
        end
    end

    assign mem_rst_n = rst_n_q;
    assign mem_cke   = cke_q;
    assign mem_cs_n  = cs_n_q;
    assign mem_ras_n = cmd_q[2];
    assign mem_cas_n = cmd_q[1];
    assign mem_we_n  = cmd_q[0];
    assign mem_ba    = ba_q;
    assign mem_addr  = addr_q;
    assign mem_odt   = odt_q;
    assign init_done = done_q;
    assign cur_rank  = rank_q;

endmodule

// File: doc/ddr3_init_sequencer.md
Name: ddr3_init_sequencer

Overview:
Synthesizable DDR3 power-up/initialization sequencer; replaces hand-timed bench stimulus for reset, cke and odt with a parametrised state machine. Drives the DRAM command pins through JEDEC init: RESET# hold, CKE wait, tXPR, MR2/MR3/MR1/MR0 loads, ZQCL. Supports multiple ranks, one rank at a time. Sits between the controller core and the PHY command path; the core owns the bus only after init_done.

Parameters:
NUM_CS, 1, number of ranks / chip selects (1..4)
BA_BITS, 3, bank address width
ADDR_BITS, 14, row/MR address width
T_RESET_CYC, 40000, cycles mem_rst_n held low (200 us)
T_CKE_CYC, 100000, cycles from mem_rst_n high to mem_cke high (500 us)
T_XPR_CYC, 64, cycles from cke high to first MRS
T_MRD_CYC, 4, MRS-to-MRS command spacing
T_MOD_CYC, 12, MR0-to-ZQCL spacing
T_ZQINIT_CYC, 512, ZQCL to next rank's MR2 or done
MR0_VAL, MR1_VAL, MR2_VAL, MR3_VAL; 14'h0; address-bus payloads per mode register
All T_* >= 1.

Ports:
ck  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
mem_rst_n  output  1  DRAM RESET#
mem_cke  output  1  DRAM CKE
mem_cs_n  output  NUM_CS  chip selects, active low
mem_ras_n  output  1  RAS#
mem_cas_n  output  1  CAS#
mem_we_n  output  1  WE#
mem_ba  output  BA_BITS  bank address / MR select
mem_addr  output  ADDR_BITS  address / MR payload
mem_odt  output  1  on-die termination; held 0 throughout init
init_done  output  1  sticky high when sequence complete
cur_rank  output  clog2(NUM_CS) (min 1)  rank being initialized

Behaviour:
- All outputs registered. Reset values: mem_rst_n=0, mem_cke=0, mem_cs_n=all 1, ras/cas/we=1, ba=0, addr=0, odt=0, init_done=0, cur_rank=0; state RESET_HOLD, counter loaded.
- Commands {ras,cas,we}: NOP=111, MRS=000, ZQCL=110 with addr[10]=1, other addr bits 0. A command is valid on exactly one cycle; all other cycles until DONE are NOP with only mem_cs_n[cur_rank]=0.
- States:
 RESET_HOLD: T_RESET_CYC cycles after rst deasserts, then mem_rst_n=1 -> CKE_WAIT.
 CKE_WAIT: after T_CKE_CYC cycles mem_cke=1 -> XPR_WAIT.
 XPR_WAIT: T_XPR_CYC cycles, deselect (cs_n all 1) -> MRS.
 MRS: issue MR2 (ba=2), MR3 (ba=3), MR1 (ba=1), MR0 (ba=0) to cur_rank, with command-to-command spacing T_MRD_CYC -> after MR0 go to MOD_WAIT.
 MOD_WAIT: ZQCL issued T_MOD_CYC cycles after MR0 -> ZQ_WAIT.
 ZQ_WAIT: T_ZQINIT_CYC cycles; then, if cur_rank<NUM_CS-1, cur_rank++ and the next rank's MR2 is issued on that cycle; otherwise -> DONE.
 DONE: init_done=1, deselect (cs_n all 1, NOP), cke=1, rst_n=1; held until rst.
- Counter wide enough for max(T_*); loaded on each state/command transition, fires at 1.
- mem_odt never asserted by this block.
- rst in any state: next edge restores all reset values and restarts at RESET_HOLD; no partial command is emitted.
- cke never falls after rising except via rst.

Optional Feature:
DDR3_INIT_SIM_SHORT_EN: when defined, the effective T_RESET_CYC and T_CKE_CYC are each 16 regardless of parameter values; all other timings unchanged. When undefined, parameter values are used as given.

Test Plan:
- NUM_CS=1, T_RESET_CYC=20, T_CKE_CYC=50: release rst -> mem_rst_n rises exactly 20 cycles later, mem_cke exactly 50 after that, odt=0 throughout.
- T_XPR_CYC=10, T_MRD_CYC=4, MR2_VAL=14'h0008 -> first MRS 10 cycles after cke rise with ba=2, addr=14'h0008; MR3/MR1/MR0 at +4/+8/+12 with ba=3/1/0 and matching payloads.
- T_MOD_CYC=12, T_ZQINIT_CYC=32 -> ZQCL 12 cycles after MR0 ({ras,cas,we}=110, addr=14'h0400); init_done rises 32 cycles later and stays high; cs_n all 1 afterwards.
- NUM_CS=2 -> rank0 sequence with cs_n=2'b10, then rank1 MR2 32 cycles after rank0 ZQCL with cs_n=2'b01 and cur_rank=1; init_done only after rank1 ZQ_WAIT.
- Assert rst for one cycle on the MR1 cycle -> next cycle all outputs at reset values; full sequence reruns with identical timing.
- Compile with DDR3_INIT_SIM_SHORT_EN, T_RESET_CYC=40000 -> mem_rst_n rises 16 cycles after rst release and mem_cke 16 cycles after that.
